// File: rtl/mux_wb_pkg.sv
// Shared types and defaults for the registered write-back source selector.
package mux_wb_pkg;

    localparam int unsigned WB_WIDTH     = 32;
    localparam int unsigned WB_NUM_IN    = 9;
    localparam int unsigned WB_CONST_VAL = 227;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/mux_wb_src.sv
// Combinational indexed select from the packed source bus.
// With MUX_WRITEBACK_CONST_EN defined, slot CONST_IDX returns CONST_VAL instead of in_bus.
module mux_wb_src
    import mux_wb_pkg::*;
#(
    parameter int unsigned WIDTH     = WB_WIDTH,
    parameter int unsigned NUM_IN    = WB_NUM_IN,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned CONST_IDX = 7,
    parameter int unsigned CONST_VAL = WB_CONST_VAL
) (
    input  logic [NUM_IN*WIDTH-1:0] in_bus_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        data_c
);

    // Out-of-range selects yield zero; the top never writes them anyway.
    always_comb begin
        data_c = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (32'(sel_i) == 32'(k)) begin
`ifdef MUX_WRITEBACK_CONST_EN
                if (32'(k) == CONST_IDX) begin
                    data_c = WIDTH'(CONST_VAL);
                end else begin
                    data_c = in_bus_i[k*WIDTH +: WIDTH];
                end
`else
                data_c = in_bus_i[k*WIDTH +: WIDTH];
`endif
            end
        end
    end

endmodule

// File: rtl/mux_writeback.sv
// Single-bit pass-through helper; the selector top is mux_writeback_seq.
module mux_wb_unused_stub (
    input  logic a_i,
    output logic a_o
);
    assign a_o = a_i;
endmodule

// File: rtl/mux_writeback_seq.sv
// Registered write-back source selector with programmable memory-source wait and error pulse.
// Optional constant slot enabled by macro MUX_WRITEBACK_CONST_EN.
module mux_writeback_seq
    import mux_wb_pkg::*;
#(
    parameter int unsigned WIDTH     = WB_WIDTH,
    parameter int unsigned NUM_IN    = WB_NUM_IN,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned MEM_IDX   = 1,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned CONST_IDX = 7,
    parameter int unsigned CONST_VAL = WB_CONST_VAL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    start,
    output logic                    busy,
    output logic                    wr_en,
    output logic [WIDTH-1:0]        wr_data,
    output logic                    err
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    wb_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               wr_en_q;
    logic               err_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic [SEL_W-1:0]   src_sel_c;
    logic [WIDTH-1:0]   src_data_c;

    // In WAIT the memory source is re-read at the capture edge, not at request time.
    assign src_sel_c = (state_q == WAIT) ? SEL_W'(MEM_IDX) : sel;

    mux_wb_src #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .SEL_W     (SEL_W),
        .CONST_IDX (CONST_IDX),
        .CONST_VAL (CONST_VAL)
    ) u_src (
        .in_bus_i (in_bus),
        .sel_i    (src_sel_c),
        .data_c   (src_data_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (32'(sel) >= NUM_IN) begin
                            err_q <= 1'b1;
                        end else if ((32'(sel) == MEM_IDX) && (MEM_LAT > 0)) begin
                            cnt_q   <= CNT_W'(MEM_LAT - 1);
                            busy_q  <= 1'b1;
                            state_q <= WAIT;
                        end else begin
                            wr_data_q <= src_data_c;
                            wr_en_q   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        wr_data_q <= src_data_c;
                        wr_en_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign err     = err_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mux_writeback_seq.sv
// Directed self-checking bench for mux_writeback_seq with MEM_LAT=2.
module tb_mux_writeback_seq;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 9;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [3:0]              sel;
    logic                    start;
    logic                    busy;
    logic                    wr_en;
    logic [WIDTH-1:0]        wr_data;
    logic                    err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_writeback_seq #(
        .WIDTH   (WIDTH),
        .NUM_IN  (NUM_IN),
        .SEL_W   (4),
        .MEM_IDX (1),
        .MEM_LAT (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_bus  (in_bus),
        .sel     (sel),
        .start   (start),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic be, input logic we,
                              input logic er, input logic [31:0] d);
        check({tag, ".busy"},    32'(busy),  32'(be));
        check({tag, ".wr_en"},   32'(wr_en), 32'(we));
        check({tag, ".err"},     32'(err),   32'(er));
        check({tag, ".wr_data"}, wr_data,    d);
    endtask

    logic [31:0] const_exp;

    initial begin
`ifdef MUX_WRITEBACK_CONST_EN
        const_exp = 32'h0000_00E3;
`else
        const_exp = 32'hFFFF_FFFF;
`endif
        reset  = 1'b1;
        start  = 1'b0;
        sel    = 4'd0;
        in_bus = '0;
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;

        // Non-memory select, latency 1, then hold
        in_bus[3*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        sel = 4'd3; start = 1'b1;
        tick();
        check_outs("sel3", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        start = 1'b0;
        tick();
        check_outs("sel3_hold", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Back-to-back non-memory requests
        in_bus[0*WIDTH +: WIDTH] = 32'h1111_1111;
        in_bus[2*WIDTH +: WIDTH] = 32'h2222_2222;
        sel = 4'd0; start = 1'b1;
        tick();
        check_outs("b2b0", 1'b0, 1'b1, 1'b0, 32'h1111_1111);
        sel = 4'd2;
        tick();
        check_outs("b2b2", 1'b0, 1'b1, 1'b0, 32'h2222_2222);
        start = 1'b0;

        // Memory wait: source changes and a start arrives during WAIT
        in_bus[1*WIDTH +: WIDTH] = 32'hAAAA_0000;
        sel = 4'd1; start = 1'b1;
        tick();
        check_outs("mem_w1", 1'b1, 1'b0, 1'b0, 32'h2222_2222);
        sel = 4'd3; start = 1'b1;
        in_bus[1*WIDTH +: WIDTH] = 32'h1234_5678;
        tick();
        check_outs("mem_w2", 1'b1, 1'b0, 1'b0, 32'h2222_2222);
        start = 1'b0;
        tick();
        check_outs("mem_strobe", 1'b0, 1'b1, 1'b0, 32'h1234_5678);
        tick();
        check_outs("mem_after", 1'b0, 1'b0, 1'b0, 32'h1234_5678);

        // Invalid select
        sel = 4'd12; start = 1'b1;
        tick();
        check_outs("inv", 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        start = 1'b0;
        tick();
        check_outs("inv_after", 1'b0, 1'b0, 1'b0, 32'h1234_5678);

        // Constant slot
        in_bus[7*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        sel = 4'd7; start = 1'b1;
        tick();
        check_outs("const", 1'b0, 1'b1, 1'b0, const_exp);
        start = 1'b0;

        // New request accepted in the strobe cycle after WAIT
        in_bus[1*WIDTH +: WIDTH] = 32'h0BAD_F00D;
        sel = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_outs("mem2_w2", 1'b1, 1'b0, 1'b0, const_exp);
        tick();
        check_outs("mem2_strobe", 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D);
        sel = 4'd3; start = 1'b1;
        tick();
        check_outs("chain", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        start = 1'b0;

        // Reset in the first WAIT cycle aborts the operation
        sel = 4'd1; start = 1'b1;
        tick();
        check_outs("abort_w1", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        reset = 1'b1; start = 1'b1;
        tick();
        check_outs("abort_rst", 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0; start = 1'b0;
        tick();
        check_outs("abort_idle", 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check_outs("abort_nostrobe", 1'b0, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_writeback_seq.md
# mux_writeback_seq

Parametrised, registered successor to the write-back source selector of the multicycle datapath. It selects one of `NUM_IN` data sources for the register-file write port and registers the result. It inserts a programmable wait for the memory-data source and pulses a one-cycle write strobe. Out-of-range selects raise an error pulse instead of driving X. It sits between the datapath source registers and the register bank, driven by the control unit.

## Interface
Parameters:
- `WIDTH`, 32: data width of every source and of the output.
- `NUM_IN`, 9: number of selectable sources.
- `SEL_W`, 4: select width; must satisfy 2^`SEL_W` ≥ `NUM_IN`.
- `MEM_IDX`, 1: index of the memory-data source.
- `MEM_LAT`, 1: extra wait cycles before the memory source is captured; 0 disables the wait.
- `CONST_IDX`, 7: index of the constant slot.
- `CONST_VAL`, 227: constant value returned at `CONST_IDX` when the constant feature is compiled in.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_bus`  in  `NUM_IN*WIDTH`: packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- `sel`  in  `SEL_W`: source index, sampled only when a request is accepted.
- `start`  in  1: write-back request.
- `busy`  out  1: high while in WAIT; requests are ignored while high.
- `wr_en`  out  1: one-cycle write strobe.
- `wr_data`  out  `WIDTH`: registered selected data; holds its last value between writes.
- `err`  out  1: one-cycle pulse on an accepted request with `sel` ≥ `NUM_IN`.

## Operation
- States: IDLE, WAIT. Reset puts the block in IDLE and sets `wr_en`=0, `err`=0, `busy`=0, `wr_data`=0, and the internal counter to 0.
- In IDLE with `start`=1, one of three things happens:
  - `sel` ≥ `NUM_IN`: `err`←1 for one cycle; no write; `wr_data` unchanged; stay in IDLE.
  - `sel`==`MEM_IDX` and `MEM_LAT`>0: latch `sel`; cnt←`MEM_LAT`-1; go to WAIT.
  - Any other valid `sel`: `wr_data`←source[`sel`]; `wr_en`←1; stay in IDLE.
- In WAIT with cnt>0: cnt←cnt-1.
- In WAIT with cnt==0: `wr_data`←source[`MEM_IDX`], sampled at that edge rather than at request time; `wr_en`←1; go to IDLE.
- `start` is ignored while in WAIT. It is not queued or stored.
- `wr_en` and `err` are never high in the same cycle.
- Back-to-back non-memory requests are allowed every cycle, giving one strobe per cycle.
- `reset` asserted in WAIT aborts the operation: no strobe is issued and outputs return to their reset values.
- `reset` and `start` asserted together: reset wins.

## Timing
- Non-memory source: request accepted at edge t; `wr_en`=1 and `wr_data` valid in the cycle after edge t (latency 1).
- Memory source: `wr_en` rises after edge t+`MEM_LAT`, giving latency `MEM_LAT`+1.
- `busy` is high for exactly `MEM_LAT` cycles, starting after edge t.
- A new request may be presented in the cycle where `wr_en` is high after WAIT, because the block is back in IDLE then.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro: `MUX_WRITEBACK_CONST_EN`.
- Defined: slot `CONST_IDX` returns `CONST_VAL`, zero-extended or truncated to `WIDTH`, and `in_bus` bits for that slot are ignored.
- Undefined: slot `CONST_IDX` is an ordinary input channel taken from `in_bus`.

## Structure
- Shared package `mux_wb_pkg` holds:
  - the state typedef (IDLE, WAIT);
  - the default `CONST_VAL` localparam (227);
  - the default `WIDTH` and `NUM_IN`.
- One natural sub-module, `mux_wb_src`: combinational indexed select from `in_bus`, including the constant substitution under the macro. The top level holds the FSM, counter and output registers.

## Test plan
- Reset: hold `reset` for 2 cycles → `wr_data`=0, `wr_en`=0, `busy`=0, `err`=0.
- Non-memory select: source 3 = 0xDEADBEEF, `start` with `sel`=3 → next cycle `wr_en`=1 and `wr_data`=0xDEADBEEF; the following cycle `wr_en`=0 and data is held.
- Memory wait with `MEM_LAT`=2:
  - request `sel`=1 → `busy`=1 for 2 cycles;
  - a `start` issued during WAIT is ignored;
  - source 1 changes to 0x12345678 during WAIT → strobe at latency 3 carries 0x12345678.
- Invalid select: `sel`=12 with `NUM_IN`=9 → `err` pulses once, no `wr_en`, `wr_data` unchanged.
- Constant slot: `sel`=7 with `in_bus` slot 7 = 0xFFFFFFFF → `wr_data`=0x000000E3 with the macro defined, 0xFFFFFFFF without it.
- Reset mid-WAIT: assert `reset` in the first WAIT cycle → no strobe; block in IDLE with all outputs zero on the next cycle.
